// File: rtl/gpu_result_collector.sv
// gpu_result_collector: once all four cores hold idle, reads back the 16x16
//   result matrix from shared RAM row-major and streams it out.
// Latency: first element is valid 2 cycles after the first read; one element per cycle after that.
// Backpressure: out_ready low holds the element; reads pause while buffered + in-flight would exceed 2.
//
// Parameters:
//   RESULT_BASE  byte address of element (0,0) in the shared RAM
//   IDLE_STABLE  consecutive all-idle cycles required before readout starts
// Ports:
//   CLK, RES                 clock; asynchronous active-high reset
//   start                    one-cycle collect request (honoured only when idle)
//   core_idle[3:0]           per-core idle flags; core k produced rows 4k..4k+3
//   rd_en, rd_addr, rd_data  shared-RAM read port, data returns 1 cycle after rd_en
//   out_valid/out_ready      result stream handshake
//   out_data/row/col/last    element value, coordinates, last marks (15,15)
//   busy, done               status; done is a single-cycle pulse
// Optional build macro GPU_COLLECT_CHECKSUM_EN adds output checksum[31:0]:
//   sum mod 2^32 of all transferred elements, held from done until the next start.

module gpu_result_collector #(
  parameter int RESULT_BASE = 1024,
  parameter int IDLE_STABLE = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        start,
  input  logic [3:0]  core_idle,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_row,
  output logic [3:0]  out_col,
  output logic        out_last,
  output logic        busy,
  output logic        done
`ifdef GPU_COLLECT_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] BASE_ADDR  = 32'(RESULT_BASE);
  localparam logic [15:0] STABLE_TGT = 16'(IDLE_STABLE);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        last;
  } elem_t;

  logic [1:0]  state;
  logic [15:0] stable_cnt;
  logic [8:0]  issue_cnt;   // reads issued so far; bit 8 set means all 256 issued
  logic        inflight;    // a read was issued last cycle, its data is on rd_data now
  logic [7:0]  infl_idx;    // element index of that in-flight read
  logic [1:0]  buf_cnt;
  elem_t       slot0;       // head of the output buffer, drives the out_* ports
  elem_t       slot1;
  elem_t       push_e;
  logic        xfer;
  logic [2:0]  occ;

  assign xfer      = out_valid & out_ready;
  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = slot0.data;
  assign out_row   = slot0.row;
  assign out_col   = slot0.col;
  // slot0 can hold a stale copy of (15,15) once drained, so qualify with valid.
  assign out_last  = out_valid & slot0.last;

  assign busy = (state == S_WAIT) || (state == S_READ);
  assign done = (state == S_DONE);

  // Occupancy after this cycle's transfer: counting the departing element
  // lets a new read go out in the same cycle, giving one element per cycle
  // with out_ready held high while never exceeding two entries in total.
  assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, xfer};
  assign rd_en = (state == S_READ) && !issue_cnt[8] && (occ < 3'd2);

  // Element i lives at RESULT_BASE + 4*i, with i = 16*row + col.
  assign rd_addr = rd_en ? (BASE_ADDR + {22'd0, issue_cnt[7:0], 2'b00}) : 32'd0;

  always_comb begin
    push_e      = '0;
    push_e.data = rd_data;
    push_e.row  = infl_idx[7:4];
    push_e.col  = infl_idx[3:0];
    push_e.last = (infl_idx == 8'hFF);
  end

  // Read issue and in-flight tracking. Clearing inflight on reset is what
  // makes the rd_data returned after reset release fall on the floor.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      inflight <= 1'b0;
      infl_idx <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        infl_idx <= issue_cnt[7:0];
      end
    end
  end

  // Two-entry output buffer, slot0 is always the head.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      buf_cnt <= '0;
      slot0   <= '0;
      slot1   <= '0;
    end else begin
      case ({inflight, xfer})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            slot0 <= push_e;
          end else begin
            slot1 <= push_e;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          slot0   <= slot1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Pop and push together: count is unchanged.
          if (buf_cnt == 2'd1) begin
            slot0 <= push_e;
          end else begin
            slot0 <= slot1;
            slot1 <= push_e;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control FSM, stable-idle counter and read address counter.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state      <= S_IDLE;
      stable_cnt <= '0;
      issue_cnt  <= '0;
    end else begin
      if (rd_en) begin
        issue_cnt <= issue_cnt + 9'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_WAIT;
            stable_cnt <= '0;
            issue_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (core_idle == 4'hF) begin
            stable_cnt <= stable_cnt + 16'd1;
            if ((stable_cnt + 16'd1) >= STABLE_TGT) begin
              state <= S_READ;
            end
          end else begin
            stable_cnt <= '0;
          end
        end
        S_READ: begin
          // core_idle is deliberately not looked at once readout has begun.
          if (xfer && out_last) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GPU_COLLECT_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      csum <= '0;
    end else if ((state == S_IDLE) && start) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum + out_data;
    end
  end

  assign checksum = csum;
`endif

endmodule

// File: tb/tb_gpu_result_collector.sv
// Self-checking bench for gpu_result_collector: randomized ready/idle
// patterns and data offsets against a scoreboard of the expected
// row-major element stream.
module tb_gpu_result_collector;

  localparam int BASE = 1024;
  localparam int STAB = 2;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  core_idle = 4'hF;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef GPU_COLLECT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  gpu_result_collector #(.RESULT_BASE(BASE), .IDLE_STABLE(STAB)) dut (
    .CLK(CLK), .RES(RES), .start(start), .core_idle(core_idle),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done)
`ifdef GPU_COLLECT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Shared RAM: element i holds i + data_off; garbage when not read.
  logic [31:0] data_off = 32'd0;
  always @(posedge CLK) begin
    if (rd_en) rd_data <= ((rd_addr - 32'(BASE)) >> 2) + data_off;
    else       rd_data <= $urandom;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state
  bit          mon_on = 0;
  int          exp_idx, rd_issued, done_cnt, last_xfer_cyc, first_rd_cyc, f_run;
  bit          saw_rd, started, last_seen;
  logic [31:0] sum_exp;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic [8:0]  prev_rcl;
  bit          m_xfer;

  always @(negedge CLK) begin
    if (mon_on && !RES) begin
      m_xfer = out_valid && out_ready;
      // Readout may begin only right after STAB consecutive all-idle cycles.
      if (start && !started) begin
        started = 1; f_run = 0;
      end else if (started && !saw_rd) begin
        chk("wait_gate", 32'(rd_en), 32'(f_run >= STAB));
        f_run = (core_idle == 4'hF) ? f_run + 1 : 0;
      end
      if (rd_en) begin
        if (!saw_rd) begin saw_rd = 1; first_rd_cyc = cyc; end
        chk("rd_addr", rd_addr, 32'(BASE + 4 * rd_issued));
        chk("no_wrap", 32'(rd_issued < 256), 32'd1);
        rd_issued++;
      end
      chk("outstanding", 32'((rd_issued - exp_idx - int'(m_xfer)) <= 2), 32'd1);
      if (saw_rd && !last_seen) chk("busy_read", 32'(busy), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_rcl", 32'({out_row, out_col, out_last}), 32'(prev_rcl));
      end
      if (m_xfer) begin
        chk("data", out_data, 32'(exp_idx) + data_off);
        chk("row", 32'(out_row), 32'(exp_idx / 16));
        chk("col", 32'(out_col), 32'(exp_idx % 16));
        chk("last", 32'(out_last), 32'(exp_idx == 255));
        sum_exp = sum_exp + 32'(exp_idx) + data_off;
        if (exp_idx == 255) begin last_seen = 1; last_xfer_cyc = cyc; end
        exp_idx++;
      end
      if (done) begin
        chk("done_timing", 32'(cyc), 32'(last_xfer_cyc + 1));
        chk("busy_done", 32'(busy), 32'd0);
`ifdef GPU_COLLECT_CHECKSUM_EN
        chk("checksum", checksum, sum_exp);
`endif
        done_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_rcl   = {out_row, out_col, out_last};
    end else begin
      prev_stall = 0;
    end
  end

  // idle_mode 0: all idle; 1: 4'h7 for 10 cycles then F;
  // 2: random for 20 cycles, then F until readout, random during readout.
  task automatic run(input int ready_pct, input int idle_mode, input bit spam, input int abort_after);
    exp_idx = 0; rd_issued = 0; done_cnt = 0; last_xfer_cyc = -10; first_rd_cyc = 0;
    f_run = 0; saw_rd = 0; started = 0; last_seen = 0; sum_exp = 0;
    mon_on = 1;
    @(posedge CLK); #1;
    start = 1;
    core_idle = (idle_mode == 0) ? 4'hF : 4'h7;
    out_ready = ($urandom_range(99) < ready_pct);
    @(posedge CLK); #1;
    start = 0;
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      if (abort_after > 0 && exp_idx >= abort_after) break;
      case (idle_mode)
        0: core_idle = 4'hF;
        1: core_idle = (n < 10) ? 4'h7 : 4'hF;
        default: core_idle = (n < 20 || saw_rd) ? 4'($urandom) : 4'hF;
      endcase
      out_ready = ($urandom_range(99) < ready_pct);
      start = spam && saw_rd && !last_seen && ($urandom_range(3) == 0);
      @(posedge CLK); #1;
    end
    start = 0;
    core_idle = 4'hF;
    if (abort_after == 0) begin
      repeat (4) @(posedge CLK);
      #1;
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("elem_count", 32'(exp_idx), 32'd256);
      chk("read_count", 32'(rd_issued), 32'd256);
      chk("busy_after", 32'(busy), 32'd0);
      if (ready_pct == 100)
        chk("throughput", 32'(last_xfer_cyc - first_rd_cyc), 32'd257);
      mon_on = 0;
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      chk("quiet_valid", 32'(out_valid), 32'd0);
      chk("quiet_rd_en", 32'(rd_en), 32'd0);
      chk("quiet_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, rd_addr, 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_rcl"}, 32'({out_row, out_col, out_last}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef GPU_COLLECT_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 32'd0);
`endif
  endtask

  initial begin
    #1 RES = 1'b1;
    #1 chk_zero("reset");
    repeat (3) @(posedge CLK);
    #1 RES = 1'b0;
    quiet(3);

    // Identity RAM, always ready, cores idle from the start.
    data_off = 32'd0;
    run(100, 0, 0, 0);
`ifdef GPU_COLLECT_CHECKSUM_EN
    chk("checksum_identity", checksum, 32'd32640);
`endif
    quiet(3);

    // Cores 0..2 idle only, then all idle.
    run(100, 1, 0, 0);

    // Random backpressure and data offset.
    data_off = $urandom;
    run(50, 0, 0, 0);
    run(30, 2, 0, 0);

    // start pulses during readout, random idle glitches.
    data_off = $urandom;
    run(50, 2, 1, 0);
    quiet(4);

    // Reset after 100 transfers.
    data_off = 32'd0;
    run(100, 0, 0, 100);
    mon_on = 0;
    #2 RES = 1'b1;
    #1 chk_zero("midreset");
    @(posedge CLK); #1;
    RES = 1'b0;
    quiet(8);
    run(100, 0, 0, 0);
    run(60, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpu_result_collector.md
GPU_RESULT_COLLECTOR -- requirements
Module: gpu_result_collector

Interface
REQ-001 SHALL have parameter RESULT_BASE, default 1024: byte address of result element (0,0) in the shared RAM.
REQ-002 SHALL have parameter IDLE_STABLE, default 2: consecutive cycles all cores must report idle before readout.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RES  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to collect a result matrix.
REQ-006 SHALL have port core_idle  input  4  bit k = IDLE of core k.
REQ-007 SHALL have port rd_en  output  1  shared-RAM read strobe.
REQ-008 SHALL have port rd_addr  output  32  shared-RAM byte read address.
REQ-009 SHALL have port rd_data  input  32  RAM read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port out_valid  output  1, out_ready  input  1, out_data  output  32  result stream with valid/ready handshake.
REQ-011 SHALL have ports out_row  output  4, out_col  output  4, out_last  output  1  coordinates of out_data; out_last marks element (15,15).
REQ-012 SHALL have ports busy  output  1 and done  output  1  status.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_CORES, READ, DONE.
REQ-014 IDLE: start=1 -> WAIT_CORES, clear stable counter, element counters and checksum; start is ignored in all other states.
REQ-015 WAIT_CORES: stable counter increments while core_idle==4'hF and clears to 0 otherwise; when it reaches IDLE_STABLE -> READ.
REQ-016 READ: element (r,c) SHALL be read from RESULT_BASE + 4*(16*r + c), row-major, r,c in 0..15, 256 reads total.
REQ-017 Rows 4k..4k+3 are produced by core k; read order is row-major regardless.
REQ-018 A 2-entry output buffer SHALL hold returned data; rd_en is asserted only when buffered entries plus in-flight reads < 2 and reads remain.
REQ-019 Element transfers when out_valid && out_ready; out_valid SHALL NOT drop and out_data/row/col/last SHALL NOT change until transfer.
REQ-020 No element is dropped or duplicated under any out_ready pattern; with out_ready held at 1, sustained throughput is one element per cycle after a 2-cycle startup.
REQ-021 Transfer of the out_last element -> DONE; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-022 busy = 1 in WAIT_CORES and READ, 0 otherwise.
REQ-023 A core_idle bit deasserting during READ SHALL be ignored.
REQ-024 Read address counter stops after 256 issues; no wrap-around read is issued.

Reset
REQ-025 RES=1 SHALL immediately force IDLE and set rd_en, out_valid, out_last, busy, done to 0; rd_addr, out_data, out_row, out_col to 0; counters and buffer to empty.
REQ-026 RES asserted mid-READ SHALL discard buffered and in-flight data; the rd_data returned after reset release SHALL be ignored.
REQ-027 After RES deasserts, the block waits for a new start.

Configuration
REQ-028 Macro GPU_COLLECT_CHECKSUM_EN defined: extra output checksum  32  sum mod 2^32 of all transferred elements, stable from done until the next start, reset value 0.
REQ-029 Macro undefined: no checksum port or logic; all other behaviour is identical.

Verification
REQ-030 RAM(i)=i for element i, out_ready=1, start with core_idle=F: 256 elements, data 0..255, (row,col) row-major, out_last only on data 255, done 1 cycle after it.
REQ-031 core_idle=7 for 10 cycles, then F: no rd_en until 2 consecutive cycles of F.
REQ-032 out_ready toggled pseudo-randomly (50%): identical 256-element sequence, never more than 2 reads outstanding or buffered.
REQ-033 RES pulse after 100 transfers: outputs zero immediately, no further out_valid; new start yields a full 0..255 sequence.
REQ-034 start pulses during READ: no restart, single done.
REQ-035 With GPU_COLLECT_CHECKSUM_EN and RAM(i)=i: checksum = 32640 at done.
